// File: rtl/shift_chain_driver.sv
// shift_chain_driver: serial driver for chains of 74HC595-style shift registers.
// Frames arrive over a valid/ready port into a one-deep pending buffer and are
// shifted out on CHANNELS parallel data lines with a shared SH_CP. An ST_CP
// pulse follows the last bit. All shift timing is derived from CLK by DIV.
//
// Handshake: a frame is taken on any rising CLK edge where frame_valid and
// frame_ready are both high. frame_ready is simply "pending buffer empty" and
// does not depend on frame_valid. frame_data must be stable while
// frame_valid is high. A taken frame is never altered by the active shift.
module shift_chain_driver #(
  parameter int NBITS     = 25,
  parameter int CHANNELS  = 1,
  parameter int DIV       = 419,
  parameter int MSB_FIRST = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS*NBITS-1:0] frame_data,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  output logic                      SH_CP,
  output logic                      ST_CP,
  output logic [CHANNELS-1:0]       data,
  output logic                      busy,
  output logic                      frame_done,
  output logic [1:0]                dbg_state
);

  localparam int W  = CHANNELS * NBITS;
  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(NBITS + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SHIFT_LO = 2'd1;
  localparam logic [1:0] S_SHIFT_HI = 2'd2;
  localparam logic [1:0] S_LATCH    = 2'd3;

  logic [1:0]    state;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [W-1:0]  pending;
  logic [W-1:0]  shreg;
  logic          pending_full;
  logic          phase_end;
  logic          handshake;

  // Returns the bit for shift position k of every channel, honouring bit order.
  function automatic logic [CHANNELS-1:0] pick_bits(input logic [W-1:0] f,
                                                     input logic [BW-1:0] k);
    logic [CHANNELS-1:0] r;
    logic [W-1:0]        tmp;
    int                  pos;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pos = (MSB_FIRST != 0) ? (c * NBITS + NBITS - 1 - int'(k))
                             : (c * NBITS + int'(k));
      tmp = f >> pos;
      r   = r | (CHANNELS'(tmp[0]) << c);
    end
    return r;
  endfunction

  // Phase timing and handshake qualifiers.
  always_comb begin
    phase_end   = (div_cnt == DIV_LAST);
    handshake   = frame_valid && !pending_full;
    frame_ready = !pending_full;
    busy        = (state != S_IDLE);
    frame_done  = (state == S_LATCH) && phase_end;
    dbg_state   = state;
  end

  // Pending buffer, shift sequencer and registered chain outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      pending      <= '0;
      shreg        <= '0;
      pending_full <= 1'b0;
      SH_CP        <= 1'b0;
      ST_CP        <= 1'b0;
      data         <= '0;
    end else begin
      if (handshake) begin
        pending      <= frame_data;
        pending_full <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          // handshake and load are exclusive: one needs the flag clear, the other set
          if (pending_full) begin
            shreg        <= pending;
            pending_full <= 1'b0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            data         <= pick_bits(pending, '0);
            state        <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          if (phase_end) begin
            div_cnt <= '0;
            SH_CP   <= 1'b1;
            state   <= S_SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (phase_end) begin
            div_cnt <= '0;
            SH_CP   <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              data  <= '0;
              ST_CP <= 1'b1;
              state <= S_LATCH;
            end else begin
              // next bit changes together with the SH_CP falling edge
              bit_cnt <= bit_cnt + 1'b1;
              data    <= pick_bits(shreg, bit_cnt + 1'b1);
              state   <= S_SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (phase_end) begin
            div_cnt <= '0;
            ST_CP   <= 1'b0;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_chain_driver.sv
// Bench for shift_chain_driver: three instances with different parameter sets.
// Monitors log every SH_CP rise (cycle and data), ST_CP edges and frame_done
// pulses; tests compare these logs with bit sequences and timing computed
// from the frame contents and the shift timing formulas.
module tb_shift_chain_driver;

  localparam int AN = 4, AC = 2, AD = 2;
  localparam int BN = 25, BD = 1;
  localparam int CN = 1, CD = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: NBITS=4, CHANNELS=2, DIV=2, LSB first
  logic [7:0] a_fd = '0;
  logic       a_fv = 1'b0;
  logic       a_fr, a_sh, a_st, a_busy, a_done;
  logic [1:0] a_dat, a_state;
  // instance B: NBITS=25, CHANNELS=1, DIV=1, MSB first
  logic [24:0] b_fd = '0;
  logic        b_fv = 1'b0;
  logic        b_fr, b_sh, b_st, b_busy, b_done;
  logic [0:0]  b_dat;
  logic [1:0]  b_state;
  // instance C: NBITS=1, CHANNELS=1, DIV=1
  logic [0:0] c_fd = '0;
  logic       c_fv = 1'b0;
  logic       c_fr, c_sh, c_st, c_busy, c_done;
  logic [0:0] c_dat;
  logic [1:0] c_state;

  shift_chain_driver #(.NBITS(AN), .CHANNELS(AC), .DIV(AD), .MSB_FIRST(0)) dut_a (
    .CLK(clk), .RST(rst), .frame_data(a_fd), .frame_valid(a_fv), .frame_ready(a_fr),
    .SH_CP(a_sh), .ST_CP(a_st), .data(a_dat), .busy(a_busy), .frame_done(a_done),
    .dbg_state(a_state));
  shift_chain_driver #(.NBITS(BN), .CHANNELS(1), .DIV(BD), .MSB_FIRST(1)) dut_b (
    .CLK(clk), .RST(rst), .frame_data(b_fd), .frame_valid(b_fv), .frame_ready(b_fr),
    .SH_CP(b_sh), .ST_CP(b_st), .data(b_dat), .busy(b_busy), .frame_done(b_done),
    .dbg_state(b_state));
  shift_chain_driver #(.NBITS(CN), .CHANNELS(1), .DIV(CD), .MSB_FIRST(0)) dut_c (
    .CLK(clk), .RST(rst), .frame_data(c_fd), .frame_valid(c_fv), .frame_ready(c_fr),
    .SH_CP(c_sh), .ST_CP(c_st), .data(c_dat), .busy(c_busy), .frame_done(c_done),
    .dbg_state(c_state));

  // event logs filled by the monitors
  int         a_rise_cyc[$], a_st_rise[$], a_st_fall[$], a_done_cyc[$];
  logic [1:0] a_rise_dat[$];
  int         a_unstable = 0;
  logic       a_sh_q = 1'b0, a_st_q = 1'b0;
  logic [1:0] a_dat_q = '0;
  int         b_rise_cyc[$], b_st_rise[$], b_done_cyc[$];
  logic [0:0] b_rise_dat[$];
  int         b_unstable = 0;
  logic       b_sh_q = 1'b0, b_st_q = 1'b0;
  logic [0:0] b_dat_q = '0;
  int         c_rise_cyc[$], c_st_rise[$], c_st_fall[$], c_done_cyc[$];
  logic [0:0] c_rise_dat[$];
  logic       c_sh_q = 1'b0, c_st_q = 1'b0;

  // expected shifted bits, one entry per SH_CP rise
  logic [1:0] exp_a[$];
  logic [0:0] exp_b[$];
  logic [0:0] exp_c[$];

  // model: bit k of each channel for LSB-first 4-bit chains (ch1 is bits 7:4)
  function automatic logic [1:0] model_a(input logic [7:0] f, input int k);
    logic [7:0] tmp;
    tmp = f >> k;
    return {tmp[4], tmp[0]};
  endfunction

  // model: MSB-first 25-bit chain, shift position k carries bit 24-k
  function automatic logic [0:0] model_b(input logic [24:0] f, input int k);
    logic [24:0] tmp;
    tmp = f >> (BN - 1 - k);
    return tmp[0];
  endfunction

  always @(negedge clk) begin
    if (a_sh && !a_sh_q) begin
      a_rise_cyc.push_back(cyc);
      a_rise_dat.push_back(a_dat);
      if (a_dat !== a_dat_q) a_unstable++;
    end
    if (a_sh && a_sh_q && (a_dat !== a_dat_q)) a_unstable++;
    if (a_st && !a_st_q) a_st_rise.push_back(cyc);
    if (!a_st && a_st_q) a_st_fall.push_back(cyc);
    if (a_done) a_done_cyc.push_back(cyc);
    a_sh_q  = a_sh;
    a_st_q  = a_st;
    a_dat_q = a_dat;

    if (b_sh && !b_sh_q) begin
      b_rise_cyc.push_back(cyc);
      b_rise_dat.push_back(b_dat);
      if (b_dat !== b_dat_q) b_unstable++;
    end
    if (b_sh && b_sh_q && (b_dat !== b_dat_q)) b_unstable++;
    if (b_st && !b_st_q) b_st_rise.push_back(cyc);
    if (b_done) b_done_cyc.push_back(cyc);
    b_sh_q  = b_sh;
    b_st_q  = b_st;
    b_dat_q = b_dat;

    if (c_sh && !c_sh_q) begin
      c_rise_cyc.push_back(cyc);
      c_rise_dat.push_back(c_dat);
    end
    if (c_st && !c_st_q) c_st_rise.push_back(cyc);
    if (!c_st && c_st_q) c_st_fall.push_back(cyc);
    if (c_done) c_done_cyc.push_back(cyc);
    c_sh_q = c_sh;
    c_st_q = c_st;
  end

  task automatic clear_a();
    a_rise_cyc.delete(); a_rise_dat.delete(); a_st_rise.delete();
    a_st_fall.delete(); a_done_cyc.delete(); exp_a.delete(); a_unstable = 0;
  endtask

  task automatic send_a(input logic [7:0] f, output int hs);
    int n;
    n = 0;
    @(posedge clk); #1;
    a_fd = f;
    a_fv = 1'b1;
    while (!a_fr && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!a_fr) begin
      total++; bad++;
      $display("FAIL send_a_timeout got ready=%b want 1 within 500 cycles", a_fr);
    end
    hs = cyc;
    @(posedge clk); #1;
    a_fv = 1'b0;
  endtask

  task automatic send_b(input logic [24:0] f, output int hs);
    int n;
    n = 0;
    @(posedge clk); #1;
    b_fd = f;
    b_fv = 1'b1;
    while (!b_fr && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!b_fr) begin
      total++; bad++;
      $display("FAIL send_b_timeout got ready=%b want 1 within 500 cycles", b_fr);
    end
    hs = cyc;
    @(posedge clk); #1;
    b_fv = 1'b0;
  endtask

  task automatic wait_done_a(input int n);
    int k;
    k = 0;
    while (a_done_cyc.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (a_done_cyc.size() < n) begin
      total++; bad++;
      $display("FAIL wait_done_a got=%0d want=%0d", a_done_cyc.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    clear_a();
    total++; if (a_sh !== 1'b0) begin bad++; $display("FAIL reset_sh got=%b want=0", a_sh); end
    total++; if (a_st !== 1'b0) begin bad++; $display("FAIL reset_st got=%b want=0", a_st); end
    total++; if (a_dat !== 2'b00) begin bad++; $display("FAIL reset_data got=%b want=00", a_dat); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", a_done); end
    total++; if (a_fr !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_fr); end
    total++; if (b_fr !== 1'b1 || c_fr !== 1'b1) begin bad++; $display("FAIL reset_ready_bc got=%b%b want=11", b_fr, c_fr); end
    repeat (20) @(negedge clk);
    total++; if (a_rise_cyc.size() != 0) begin bad++; $display("FAIL reset_quiet_sh got=%0d rises want=0", a_rise_cyc.size()); end
    total++; if (a_st_rise.size() != 0) begin bad++; $display("FAIL reset_quiet_st got=%0d pulses want=0", a_st_rise.size()); end
  endtask

  task automatic test_single_frame();
    int t;
    clear_a();
    send_a(8'hA5, t);
    for (int k = 0; k < AN; k++) exp_a.push_back(model_a(8'hA5, k));
    wait_done_a(1);
    total++; if (a_rise_cyc.size() != AN) begin bad++; $display("FAIL single_rises got=%0d want=%0d", a_rise_cyc.size(), AN); end
    for (int k = 0; k < AN; k++) begin
      total++;
      if (a_rise_dat[k] !== exp_a[k]) begin bad++; $display("FAIL single_bit%0d got=%b want=%b", k, a_rise_dat[k], exp_a[k]); end
      total++;
      if (a_rise_cyc[k] != t + 2 + AD + 2 * k * AD) begin
        bad++; $display("FAIL single_rise_cyc%0d got=%0d want=%0d", k, a_rise_cyc[k], t + 2 + AD + 2 * k * AD);
      end
    end
    total++; if (a_st_rise.size() != 1 || a_st_rise[0] != t + 2 + 2 * AN * AD) begin
      bad++; $display("FAIL single_st_rise got=%0d want=%0d", a_st_rise[0], t + 2 + 2 * AN * AD); end
    total++; if (a_st_fall.size() != 1 || a_st_fall[0] - a_st_rise[0] != AD) begin
      bad++; $display("FAIL single_st_width got=%0d want=%0d", a_st_fall[0] - a_st_rise[0], AD); end
    total++; if (a_done_cyc.size() != 1 || a_done_cyc[0] != t + 1 + (2 * AN + 1) * AD) begin
      bad++; $display("FAIL single_done got=%0d pulses at %0d want 1 at %0d", a_done_cyc.size(), a_done_cyc[0], t + 1 + (2 * AN + 1) * AD); end
    total++; if (a_unstable != 0) begin bad++; $display("FAIL single_stability got=%0d changes want=0", a_unstable); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", a_busy); end
  endtask

  task automatic test_queueing();
    logic [7:0] f[3];
    int ta, tb, tc;
    clear_a();
    for (int i = 0; i < 3; i++) f[i] = 8'($urandom_range(0, 255));
    send_a(f[0], ta);
    send_a(f[1], tb);
    @(negedge clk);
    total++; if (a_fr !== 1'b0) begin bad++; $display("FAIL queue_ready_drop got=%b want=0", a_fr); end
    send_a(f[2], tc);
    total++; if (tc != ta + 3 + (2 * AN + 1) * AD) begin
      bad++; $display("FAIL queue_third_blocked got=%0d want=%0d", tc, ta + 3 + (2 * AN + 1) * AD); end
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < AN; k++) exp_a.push_back(model_a(f[i], k));
    wait_done_a(3);
    total++; if (a_rise_cyc.size() != 3 * AN) begin bad++; $display("FAIL queue_rises got=%0d want=%0d", a_rise_cyc.size(), 3 * AN); end
    for (int k = 0; k < 3 * AN; k++) begin
      total++;
      if (a_rise_dat[k] !== exp_a[k]) begin bad++; $display("FAIL queue_bit%0d got=%b want=%b", k, a_rise_dat[k], exp_a[k]); end
    end
    total++; if (a_rise_cyc[AN] - a_st_fall[0] != AD + 1) begin
      bad++; $display("FAIL queue_gap got=%0d want=%0d", a_rise_cyc[AN] - a_st_fall[0], AD + 1); end
    total++; if (a_rise_cyc[2 * AN] - a_rise_cyc[AN] != (2 * AN + 1) * AD + 1) begin
      bad++; $display("FAIL queue_period got=%0d want=%0d", a_rise_cyc[2 * AN] - a_rise_cyc[AN], (2 * AN + 1) * AD + 1); end
    total++; if (a_st_rise.size() != 3 || a_done_cyc.size() != 3) begin
      bad++; $display("FAIL queue_latches got=%0d/%0d want=3/3", a_st_rise.size(), a_done_cyc.size()); end
    total++; if (a_unstable != 0) begin bad++; $display("FAIL queue_stability got=%0d want=0", a_unstable); end
  endtask

  task automatic test_random_frames();
    logic [7:0] f;
    int t;
    clear_a();
    for (int i = 0; i < 4; i++) begin
      f = 8'($urandom_range(0, 255));
      for (int k = 0; k < AN; k++) exp_a.push_back(model_a(f, k));
      send_a(f, t);
    end
    wait_done_a(4);
    total++; if (a_rise_dat.size() != exp_a.size()) begin
      bad++; $display("FAIL random_rises got=%0d want=%0d", a_rise_dat.size(), exp_a.size()); end
    for (int k = 0; k < exp_a.size(); k++) begin
      total++;
      if (a_rise_dat[k] !== exp_a[k]) begin bad++; $display("FAIL random_bit%0d got=%b want=%b", k, a_rise_dat[k], exp_a[k]); end
    end
    total++; if (a_done_cyc.size() != 4) begin bad++; $display("FAIL random_done got=%0d want=4", a_done_cyc.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int t, k;
    clear_a();
    send_a(8'($urandom_range(0, 255)), t);
    send_a(8'($urandom_range(0, 255)), t);
    k = 0;
    while (a_rise_cyc.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    total++; if (a_rise_cyc.size() != 2) begin bad++; $display("FAIL midrst_second_rise got=%0d want=2", a_rise_cyc.size()); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (a_sh !== 1'b0 || a_st !== 1'b0) begin bad++; $display("FAIL midrst_clocks got=%b%b want=00", a_sh, a_st); end
    total++; if (a_dat !== 2'b00) begin bad++; $display("FAIL midrst_data got=%b want=00", a_dat); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", a_busy); end
    total++; if (a_fr !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", a_fr); end
    repeat (60) @(negedge clk);
    total++; if (a_rise_cyc.size() != 2) begin bad++; $display("FAIL midrst_no_more_shift got=%0d want=2", a_rise_cyc.size()); end
    total++; if (a_st_rise.size() != 0 || a_done_cyc.size() != 0) begin
      bad++; $display("FAIL midrst_no_latch got=%0d/%0d want=0/0", a_st_rise.size(), a_done_cyc.size()); end
  endtask

  task automatic test_msb_first();
    logic [24:0] f[2];
    int t0, t1, k;
    f[0] = 25'h1000001;
    f[1] = 25'($urandom_range(0, 32'h1FFFFFF));
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < BN; j++) exp_b.push_back(model_b(f[i], j));
    send_b(f[0], t0);
    send_b(f[1], t1);
    k = 0;
    while (b_done_cyc.size() < 2 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    total++; if (b_rise_cyc.size() != 2 * BN) begin bad++; $display("FAIL msb_rises got=%0d want=%0d", b_rise_cyc.size(), 2 * BN); end
    for (int j = 0; j < 2 * BN; j++) begin
      total++;
      if (b_rise_dat[j] !== exp_b[j]) begin bad++; $display("FAIL msb_bit%0d got=%b want=%b", j, b_rise_dat[j], exp_b[j]); end
    end
    total++; if (b_rise_cyc[0] != t0 + 2 + BD) begin bad++; $display("FAIL msb_first_rise got=%0d want=%0d", b_rise_cyc[0], t0 + 2 + BD); end
    total++; if (b_st_rise.size() != 2 || b_done_cyc.size() != 2) begin
      bad++; $display("FAIL msb_latches got=%0d/%0d want=2/2", b_st_rise.size(), b_done_cyc.size()); end
    total++; if (b_st_rise[0] != t0 + 2 + 2 * BN * BD) begin bad++; $display("FAIL msb_st_rise got=%0d want=%0d", b_st_rise[0], t0 + 2 + 2 * BN * BD); end
    total++; if (b_unstable != 0) begin bad++; $display("FAIL msb_stability got=%0d want=0", b_unstable); end
  endtask

  task automatic test_min_params();
    int acc, n, k;
    acc = 0;
    n = 0;
    @(posedge clk); #1;
    c_fv = 1'b1;
    c_fd = 1'($urandom_range(0, 1));
    while (acc < 6 && n < 200) begin
      if (c_fr) begin
        exp_c.push_back(c_fd);
        acc++;
      end
      @(posedge clk); #1;
      n++;
      c_fd = 1'($urandom_range(0, 1));
    end
    c_fv = 1'b0;
    k = 0;
    while (c_done_cyc.size() < 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    total++; if (c_rise_cyc.size() != 6) begin bad++; $display("FAIL min_rises got=%0d want=6", c_rise_cyc.size()); end
    for (int j = 0; j < 6; j++) begin
      total++;
      if (c_rise_dat[j] !== exp_c[j]) begin bad++; $display("FAIL min_bit%0d got=%b want=%b", j, c_rise_dat[j], exp_c[j]); end
    end
    for (int j = 1; j < 6; j++) begin
      total++;
      if (c_rise_cyc[j] - c_rise_cyc[j-1] != (2 * CN + 1) * CD + 1) begin
        bad++; $display("FAIL min_period%0d got=%0d want=%0d", j, c_rise_cyc[j] - c_rise_cyc[j-1], (2 * CN + 1) * CD + 1);
      end
    end
    total++; if (c_st_rise.size() != 6 || c_done_cyc.size() != 6) begin
      bad++; $display("FAIL min_latches got=%0d/%0d want=6/6", c_st_rise.size(), c_done_cyc.size()); end
    total++; if (c_st_fall.size() != 6 || c_st_fall[5] - c_st_rise[5] != CD) begin
      bad++; $display("FAIL min_st_width got=%0d want=%0d", c_st_fall[5] - c_st_rise[5], CD); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_queueing();
    test_random_frames();
    test_reset_mid_frame();
    test_msb_first();
    test_min_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
